// File: rtl/qtcore_datapath.sv
// qtcore_datapath: PC / IR / ACC register datapath for the qtcore accumulator CPU.
// Applies the control unit's mux selects and enables, drives memory/ALU operands,
// and threads all architectural state onto a single 21-bit scan chain.
module qtcore_datapath #(
    parameter int ADDR_W = 5,
    parameter int DATA_W = 8
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              processor_enable,
    input  logic              PC_write_enable,
    input  logic [1:0]        PC_mux_select,
    input  logic              ACC_write_enable,
    input  logic [1:0]        ACC_mux_select,
    input  logic              IR_load_enable,
    input  logic              ALU_inputB_mux_select,
    input  logic              Memory_write_enable,
    input  logic [1:0]        Memory_address_mux_select,
    input  logic [DATA_W-1:0] alu_result,
    input  logic [DATA_W-1:0] mem_rdata,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [DATA_W-1:0] mem_wdata,
    output logic              mem_we,
    output logic [DATA_W-1:0] alu_a,
    output logic [DATA_W-1:0] alu_b,
    output logic [DATA_W-1:0] instruction,
    output logic              ZF,
    output logic [ADDR_W-1:0] pc_out,
    input  logic              scan_enable,
    input  logic              scan_in,
    output logic              scan_out
);

    logic [ADDR_W-1:0] pc_q, pc_d;
    logic [DATA_W-1:0] ir_q, ir_d;
    logic [DATA_W-1:0] acc_q, acc_d;
    logic [ADDR_W-1:0] pc_mux;
    logic [DATA_W-1:0] acc_mux;

    // PC and ACC source muxes; all inputs are pre-edge state so JSR swaps cleanly
    always_comb begin
        pc_mux = pc_q + ADDR_W'(1);
        unique case (PC_mux_select)
            2'b00: pc_mux = pc_q + ADDR_W'(1);
            2'b01: pc_mux = acc_q[ADDR_W-1:0];
            2'b10: pc_mux = pc_q - ADDR_W'(3);
            2'b11: pc_mux = pc_q + ADDR_W'(2);
            default: pc_mux = pc_q;
        endcase
        acc_mux = acc_q;
        unique case (ACC_mux_select)
            2'b00: acc_mux = alu_result;
            2'b01: acc_mux = mem_rdata;
            2'b10: acc_mux = {{(DATA_W-ADDR_W){1'b0}}, pc_q};
            2'b11: acc_mux = acc_q;
            default: acc_mux = acc_q;
        endcase
    end

    // Next state: scan shift takes precedence over the functional update
    always_comb begin
        pc_d  = pc_q;
        ir_d  = ir_q;
        acc_d = acc_q;
        if (scan_enable) begin
            {acc_d, ir_d, pc_d} = {acc_q[DATA_W-2:0], ir_q, pc_q, scan_in};
        end else if (processor_enable) begin
            if (PC_write_enable)  pc_d  = pc_mux;
            if (IR_load_enable)   ir_d  = mem_rdata;
            if (ACC_write_enable) acc_d = acc_mux;
        end
    end

    // State registers with synchronous reset
    always_ff @(posedge clk) begin
        if (rst) begin
            pc_q  <= '0;
            ir_q  <= '0;
            acc_q <= '0;
        end else begin
            pc_q  <= pc_d;
            ir_q  <= ir_d;
            acc_q <= acc_d;
        end
    end

    // Combinational outputs: address/operand muxes, store strobe gated off during scan
    always_comb begin
        mem_addr = ir_q[ADDR_W-1:0];
        unique case (Memory_address_mux_select)
            2'b00: mem_addr = ir_q[ADDR_W-1:0];
            2'b01: mem_addr = acc_q[ADDR_W-1:0];
            2'b10: mem_addr = pc_q;
            2'b11: mem_addr = '0;
            default: mem_addr = '0;
        endcase
        alu_b       = ALU_inputB_mux_select ? {{(DATA_W-4){1'b0}}, ir_q[3:0]} : mem_rdata;
        alu_a       = acc_q;
        mem_wdata   = acc_q;
        mem_we      = Memory_write_enable & processor_enable & ~scan_enable;
        instruction = ir_q;
        ZF          = (acc_q == '0);
        pc_out      = pc_q;
        scan_out    = acc_q[DATA_W-1];
    end

endmodule

// File: tb/tb_qtcore_datapath.sv
// tb_qtcore_datapath: table-driven vectors with a scoreboard queue, plus scan and reset sequences.
module tb_qtcore_datapath;

    logic       clk = 1'b0;
    logic       rst, processor_enable, PC_write_enable, ACC_write_enable, IR_load_enable;
    logic [1:0] PC_mux_select, ACC_mux_select, Memory_address_mux_select;
    logic       ALU_inputB_mux_select, Memory_write_enable, scan_enable, scan_in;
    logic [7:0] alu_result, mem_rdata;
    logic [4:0] mem_addr, pc_out;
    logic [7:0] mem_wdata, alu_a, alu_b, instruction;
    logic       mem_we, ZF, scan_out;

    int errors = 0;
    int checks = 0;

    always #5 clk = ~clk;

    qtcore_datapath dut (
        .clk(clk), .rst(rst), .processor_enable(processor_enable),
        .PC_write_enable(PC_write_enable), .PC_mux_select(PC_mux_select),
        .ACC_write_enable(ACC_write_enable), .ACC_mux_select(ACC_mux_select),
        .IR_load_enable(IR_load_enable), .ALU_inputB_mux_select(ALU_inputB_mux_select),
        .Memory_write_enable(Memory_write_enable),
        .Memory_address_mux_select(Memory_address_mux_select),
        .alu_result(alu_result), .mem_rdata(mem_rdata), .mem_addr(mem_addr),
        .mem_wdata(mem_wdata), .mem_we(mem_we), .alu_a(alu_a), .alu_b(alu_b),
        .instruction(instruction), .ZF(ZF), .pc_out(pc_out),
        .scan_enable(scan_enable), .scan_in(scan_in), .scan_out(scan_out)
    );

    typedef struct {
        logic       pe, pcwe; logic [1:0] pcsel;
        logic       accwe;    logic [1:0] accsel;
        logic       irld, bsel, mwe; logic [1:0] masel;
        logic [7:0] alu, rd;  logic rst;
        logic [4:0] e_addr;   logic [7:0] e_b; logic e_we;
        logic [4:0] e_pc;     logic [7:0] e_ir, e_acc;
    } vec_t;

    typedef struct {
        int         idx;
        logic [4:0] pc;
        logic [7:0] ir, acc;
    } exp_t;

    localparam int NV = 22;
    vec_t vec [NV];
    exp_t sb_q [$];
    logic scan_q [$];

    function automatic vec_t mk(input logic pe, pcwe, input logic [1:0] pcsel,
                                input logic accwe, input logic [1:0] accsel,
                                input logic irld, bsel, mwe, input logic [1:0] masel,
                                input logic [7:0] alu, rd, input logic r,
                                input logic [4:0] ea, input logic [7:0] eb, input logic ew,
                                input logic [4:0] epc, input logic [7:0] eir, eacc);
        vec_t v;
        v.pe = pe; v.pcwe = pcwe; v.pcsel = pcsel; v.accwe = accwe; v.accsel = accsel;
        v.irld = irld; v.bsel = bsel; v.mwe = mwe; v.masel = masel;
        v.alu = alu; v.rd = rd; v.rst = r;
        v.e_addr = ea; v.e_b = eb; v.e_we = ew; v.e_pc = epc; v.e_ir = eir; v.e_acc = eacc;
        return v;
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h, expected %0h", name, act, exp);
        end
    endtask

    task automatic idle_inputs();
        rst = 0; processor_enable = 1; PC_write_enable = 0; PC_mux_select = 0;
        ACC_write_enable = 0; ACC_mux_select = 0; IR_load_enable = 0;
        ALU_inputB_mux_select = 0; Memory_write_enable = 0; Memory_address_mux_select = 0;
        alu_result = 0; mem_rdata = 0; scan_enable = 0; scan_in = 0;
    endtask

    task automatic check_state(input string tag, input logic [4:0] pc, input logic [7:0] ir,
                               input logic [7:0] acc);
        chk({tag, "_pc"}, pc_out, pc);
        chk({tag, "_ir"}, instruction, ir);
        chk({tag, "_acc"}, alu_a, acc);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "timeout");
    end

    initial begin
        logic [7:0] cur_acc;
        exp_t e;
        logic sb;

        //                pe pw ps aw as ir bs mw ma alu    rd     rst  addr  b      we  pc  ir     acc
        vec[0]  = mk(1, 0, 0, 1, 1, 0, 0, 0, 0, 8'h00, 8'h1F, 0,   0, 8'h1F, 0,   0, 8'h00, 8'h1F);
        vec[1]  = mk(1, 1, 1, 0, 0, 0, 0, 0, 1, 8'h00, 8'h00, 0,  31, 8'h00, 0,  31, 8'h00, 8'h1F);
        vec[2]  = mk(1, 1, 0, 0, 0, 0, 0, 0, 2, 8'h00, 8'h00, 0,  31, 8'h00, 0,   0, 8'h00, 8'h1F);
        vec[3]  = mk(1, 1, 1, 0, 0, 0, 0, 0, 3, 8'h00, 8'h00, 0,   0, 8'h00, 0,  31, 8'h00, 8'h1F);
        vec[4]  = mk(1, 1, 3, 0, 0, 0, 0, 0, 2, 8'h00, 8'h00, 0,  31, 8'h00, 0,   1, 8'h00, 8'h1F);
        vec[5]  = mk(1, 1, 2, 0, 0, 0, 0, 0, 2, 8'h00, 8'h00, 0,   1, 8'h00, 0,  30, 8'h00, 8'h1F);
        vec[6]  = mk(1, 0, 0, 1, 1, 0, 0, 0, 2, 8'h00, 8'hE7, 0,  30, 8'hE7, 0,  30, 8'h00, 8'hE7);
        vec[7]  = mk(1, 1, 1, 0, 0, 0, 0, 0, 1, 8'h00, 8'h00, 0,   7, 8'h00, 0,   7, 8'h00, 8'hE7);
        vec[8]  = mk(1, 0, 0, 1, 1, 0, 0, 0, 0, 8'h00, 8'h05, 0,   0, 8'h05, 0,   7, 8'h00, 8'h05);
        vec[9]  = mk(1, 1, 1, 0, 0, 0, 0, 0, 0, 8'h00, 8'h00, 0,   0, 8'h00, 0,   5, 8'h00, 8'h05);
        vec[10] = mk(1, 0, 0, 1, 1, 0, 0, 0, 0, 8'h00, 8'h12, 0,   0, 8'h12, 0,   5, 8'h00, 8'h12);
        vec[11] = mk(1, 1, 1, 1, 2, 0, 0, 0, 1, 8'h00, 8'h00, 0,  18, 8'h00, 0,  18, 8'h00, 8'h05);
        vec[12] = mk(1, 0, 0, 1, 1, 0, 0, 0, 0, 8'h00, 8'h03, 0,   0, 8'h03, 0,  18, 8'h00, 8'h03);
        vec[13] = mk(1, 1, 1, 0, 0, 0, 0, 0, 0, 8'h00, 8'h00, 0,   0, 8'h00, 0,   3, 8'h00, 8'h03);
        vec[14] = mk(1, 0, 0, 0, 0, 1, 0, 0, 2, 8'h00, 8'hE4, 0,   3, 8'hE4, 0,   3, 8'hE4, 8'h03);
        vec[15] = mk(1, 0, 0, 1, 0, 0, 1, 0, 0, 8'h07, 8'h99, 0,   4, 8'h04, 0,   3, 8'hE4, 8'h07);
        vec[16] = mk(1, 0, 0, 1, 3, 0, 0, 0, 1, 8'h55, 8'h66, 0,   7, 8'h66, 0,   3, 8'hE4, 8'h07);
        vec[17] = mk(1, 0, 0, 0, 0, 0, 0, 1, 0, 8'h00, 8'h00, 0,   4, 8'h00, 1,   3, 8'hE4, 8'h07);
        vec[18] = mk(0, 1, 0, 1, 1, 1, 0, 1, 2, 8'h00, 8'h3C, 0,   3, 8'h3C, 0,   3, 8'hE4, 8'h07);
        vec[19] = mk(1, 1, 0, 1, 0, 1, 0, 0, 2, 8'h00, 8'h5A, 0,   3, 8'h5A, 0,   4, 8'h5A, 8'h00);
        vec[20] = mk(1, 0, 0, 1, 1, 0, 0, 0, 0, 8'h00, 8'hC3, 0,  26, 8'hC3, 0,   4, 8'h5A, 8'hC3);
        vec[21] = mk(1, 1, 3, 1, 1, 1, 0, 1, 0, 8'h00, 8'h77, 1,  26, 8'h77, 1,   0, 8'h00, 8'h00);

        // Initial reset
        idle_inputs();
        rst = 1;
        @(posedge clk); @(posedge clk); #1;
        rst = 0;
        check_state("reset", 5'd0, 8'h00, 8'h00);
        chk("reset_zf", ZF, 1'b1);
        chk("reset_scan_out", scan_out, 1'b0);
        chk("reset_wdata", mem_wdata, 8'h00);
        chk("reset_addr", mem_addr, 5'd0);
        cur_acc = 8'h00;

        // Table-driven functional vectors
        for (int i = 0; i < NV; i++) begin
            processor_enable = vec[i].pe; PC_write_enable = vec[i].pcwe;
            PC_mux_select = vec[i].pcsel; ACC_write_enable = vec[i].accwe;
            ACC_mux_select = vec[i].accsel; IR_load_enable = vec[i].irld;
            ALU_inputB_mux_select = vec[i].bsel; Memory_write_enable = vec[i].mwe;
            Memory_address_mux_select = vec[i].masel; alu_result = vec[i].alu;
            mem_rdata = vec[i].rd; rst = vec[i].rst;
            #1;
            chk($sformatf("v%0d_addr", i), mem_addr, vec[i].e_addr);
            chk($sformatf("v%0d_alu_b", i), alu_b, vec[i].e_b);
            chk($sformatf("v%0d_mem_we", i), mem_we, vec[i].e_we);
            chk($sformatf("v%0d_zf", i), ZF, cur_acc == 8'h00);
            chk($sformatf("v%0d_wdata", i), mem_wdata, cur_acc);
            e.idx = i; e.pc = vec[i].e_pc; e.ir = vec[i].e_ir; e.acc = vec[i].e_acc;
            sb_q.push_back(e);
            @(posedge clk); #1;
            e = sb_q.pop_front();
            check_state($sformatf("v%0d", e.idx), e.pc, e.ir, e.acc);
            cur_acc = e.acc;
        end
        idle_inputs();

        // Scan load: 1 then alternating, processor disabled, functional enables all high
        processor_enable = 0; scan_enable = 1;
        PC_write_enable = 1; ACC_write_enable = 1; IR_load_enable = 1;
        Memory_write_enable = 1; mem_rdata = 8'hFF; alu_result = 8'hFF;
        for (int k = 0; k < 21; k++) begin
            scan_in = (k % 2 == 0);
            scan_q.push_back(scan_in);
            #1;
            if (k % 7 == 0) chk($sformatf("scan_we_%0d", k), mem_we, 1'b0);
            @(posedge clk); #1;
        end
        check_state("scan_load", 5'h15, 8'hAA, 8'hAA);
        chk("scan_load_out", scan_out, 1'b1);

        // Scan unload: pattern emerges in the order it went in
        processor_enable = 1;
        for (int k = 0; k < 21; k++) begin
            scan_in = 0;
            #1;
            sb = scan_q.pop_front();
            chk($sformatf("unload_%0d", k), scan_out, sb);
            @(posedge clk); #1;
        end
        check_state("scan_unload", 5'd0, 8'h00, 8'h00);

        // Reset in the middle of a scan, then shifting resumes from zero
        idle_inputs();
        scan_enable = 1; scan_in = 1;
        repeat (3) @(posedge clk);
        #1;
        check_state("midscan", 5'd7, 8'h00, 8'h00);
        rst = 1;
        @(posedge clk); #1;
        check_state("midscan_rst", 5'd0, 8'h00, 8'h00);
        rst = 0;
        @(posedge clk); #1;
        check_state("midscan_resume", 5'd1, 8'h00, 8'h00);
        idle_inputs();

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/qtcore_datapath.md
# qtcore_datapath

Architectural register datapath for the qtcore accumulator CPU: holds the 5-bit PC, 8-bit IR and 8-bit ACC, applies the control unit's mux selects and write enables each cycle, and presents the memory address, write data and ALU operands. It sits directly downstream of the control unit, consuming its strobes, and feeds back the instruction and zero flag it needs. All three registers sit on one scan chain for test access and program/state observation.

## Interface
- ADDR_W, 5, PC / memory address width (32-byte memory)
- DATA_W, 8, ACC / IR / memory data width
- clk  in  1  system clock, all state on rising edge
- rst  in  1  synchronous, active-high reset
- processor_enable  in  1  functional update enable; 0 freezes PC/IR/ACC (scan still works)
- PC_write_enable  in  1  load PC from PC mux
- PC_mux_select  in  2  00 PC+1, 01 ACC[4:0], 10 PC-3, 11 PC+2
- ACC_write_enable  in  1  load ACC from ACC mux
- ACC_mux_select  in  2  00 alu_result, 01 mem_rdata, 10 {3'b000,PC}, 11 ACC (hold)
- IR_load_enable  in  1  load IR from mem_rdata
- ALU_inputB_mux_select  in  1  0 mem_rdata, 1 {4'b0000, IR[3:0]} (immediate, zero-extended)
- Memory_write_enable  in  1  STA strobe
- Memory_address_mux_select  in  2  00 IR[4:0], 01 ACC[4:0], 10 PC, 11 5'd0
- alu_result  in  8  result from ALU
- mem_rdata  in  8  memory read data (combinational on mem_addr)
- mem_addr  out  5  memory address
- mem_wdata  out  8  always ACC
- mem_we  out  1  Memory_write_enable & processor_enable & !scan_enable
- alu_a  out  8  always ACC
- alu_b  out  8  per ALU_inputB_mux_select
- instruction  out  8  IR contents, to control unit
- ZF  out  1  (ACC == 8'h00), combinational
- pc_out  out  5  PC contents (debug)
- scan_enable  in  1  shift all datapath state one bit per cycle
- scan_in  in  1  chain input
- scan_out  out  1  chain output

## Operation
- Registers: PC[4:0], IR[7:0], ACC[7:0]; reset value of all three 0. Outputs after reset: mem_addr per select (0 with select 00/10/11), mem_wdata 0, ZF 1, instruction 0, scan_out 0.
- Per-edge priority: rst > scan_enable > functional update.
- Functional update (processor_enable=1, scan_enable=0): each register loads independently when its enable is high; otherwise holds. All mux inputs sampled from pre-edge values (JSR: ACC gets old PC while PC gets ACC same edge).
- PC arithmetic is modulo 32: PC+1 of 31 is 0, PC+2 of 31 is 1, PC-3 of 1 is 30. ACC source truncated to ACC[4:0].
- ACC_mux_select 11 with ACC_write_enable=1: ACC unchanged.
- processor_enable=0: no register changes, mem_we forced 0; combinational outputs stay valid.
- Scan chain (scan_enable=1, any processor_enable): 21-bit shift register, order scan_in -> PC[0]..PC[4] -> IR[0]..IR[7] -> ACC[0]..ACC[7] -> scan_out; each edge shifts one position toward scan_out; scan_out = ACC[7] (registered, no combinational path from scan_in).
- mem_we blocked during scan so chain loading never corrupts memory.

## Timing
- Register loads take effect on the edge where the enable is sampled high; visible next cycle.
- mem_addr, alu_a, alu_b, ZF, mem_we: combinational from current state and inputs, same cycle.
- Full chain load/unload: 21 cycles with scan_enable held high; after exactly 21 shifts the register contents equal the 21 bits presented (first bit presented ends in ACC[7]).
- rst asserted mid-scan or mid-instruction: all registers 0 on that edge; shift resumes from zeroed state if scan_enable remains high after rst drops.
- Simultaneous PC_write_enable, ACC_write_enable, IR_load_enable in one cycle: all three load independently.

## Test plan
- Reset: drive state nonzero, assert rst one cycle -> PC=0, IR=0, ACC=0, ZF=1, scan_out=0.
- PC muxes: PC=31, select 00 -> 0; PC=31, select 11 -> 1; PC=1, select 10 -> 30; ACC=8'hE7, select 01 -> PC=7.
- JSR swap: PC=5, ACC=8'h12, PC_mux=01, ACC_mux=10, both enables -> PC=18, ACC=8'h05.
- Fetch/ADDI: mem_addr select 10, PC=3, mem_rdata=8'hE4, IR_load -> IR=8'hE4; next cycle ALU_inputB_mux_select=1 -> alu_b=8'h04.
- Store gating: Memory_write_enable=1 with processor_enable=0 -> mem_we=0; with scan_enable=1 -> mem_we=0; with both enables proper -> mem_we=1, mem_wdata=ACC.
- Scan: shift in 21-bit pattern 1'b1 then alternating, 21 cycles -> ACC[7]=1, PC/IR/ACC match pattern; shift 21 more with scan_in=0 -> scan_out reproduces pattern in order, registers all 0; processor_enable=0 throughout has no effect.
